// File: rtl/uart_command_decoder.sv
// UART command front end: assembles 32-bit LSB-first command words from the RX FIFO,
// drives the core clock divider, core reset and memory port, and returns a 4-byte response.
module uart_command_decoder #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_read,
  input  logic [7:0]  rx_fifo_read_data,
  input  logic        tx_fifo_full,
  output logic        tx_fifo_write,
  output logic [7:0]  tx_fifo_write_data,
  output logic        clk_div_write_pulse,
  output logic        clk_div_option,
  output logic        clk_div_out_enable,
  output logic [31:0] clk_div_divider,
  output logic [31:0] clk_div_pulse,
  output logic        reset_core,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ack,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_PULSE = 8'h43;
  localparam logic [7:0] OP_AUTO  = 8'h41;
  localparam logic [7:0] OP_STOP  = 8'h53;
  localparam logic [7:0] OP_RESET = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_LOAD  = 8'h4C;
  localparam logic [7:0] OP_PING  = 8'h70;

  localparam logic [31:0] RESP_ACK  = 32'h0000_4B4F;
  localparam logic [31:0] RESP_ERR  = 32'hFFFF_FFFF;
  localparam logic [31:0] RESP_PONG = 32'h504F_4E47;

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, DECODE, DATA_FETCH, DATA_CAPTURE, MEM, RESP
  } state_t;

  state_t        state, state_next;
  logic [1:0]    cnt;
  logic [31:0]   cmd_word;
  logic [31:0]   resp_word;
  logic [TW-1:0] idle_timer;
  logic [7:0]    op;
  logic [23:0]   cmd_arg;
  logic          timer_armed;
  logic          timed_out;

  assign op      = cmd_word[7:0];
  assign cmd_arg = cmd_word[31:8];

  // The data phase of 'W' always follows captured command bytes, so it is always guarded.
  assign timer_armed = (state == FETCH && cnt != 2'd0) || state == DATA_FETCH;
  assign timed_out   = timer_armed && rx_fifo_empty && idle_timer == TW'(TIMEOUT_CYCLES - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no path through this block leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:         if (!rx_fifo_empty) state_next = CAPTURE;
      FETCH: begin
        if (!rx_fifo_empty) state_next = CAPTURE;
        else if (timed_out) state_next = IDLE;
      end
      CAPTURE:      state_next = (cnt == 2'd3) ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_WRITE: state_next = DATA_FETCH;
          OP_LOAD:  state_next = MEM;
          default:  state_next = RESP;
        endcase
      end
      DATA_FETCH: begin
        if (!rx_fifo_empty) state_next = DATA_CAPTURE;
        else if (timed_out) state_next = IDLE;
      end
      DATA_CAPTURE: state_next = (cnt == 2'd3) ? MEM : DATA_FETCH;
      MEM:          if (mem_ack) state_next = RESP;
      RESP:         if (!tx_fifo_full && cnt == 2'd3) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_fifo_read       = 1'b0;
    tx_fifo_write      = 1'b0;
    tx_fifo_write_data = resp_word[{cnt, 3'b000} +: 8];
    busy               = (state != IDLE);
    case (state)
      IDLE, FETCH, DATA_FETCH: rx_fifo_read  = !rx_fifo_empty;
      RESP:                    tx_fifo_write = !tx_fifo_full;
      default: ;
    endcase
  end

  // One shared 2-bit counter indexes command bytes, data bytes and response bytes in turn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt                 <= '0;
      cmd_word            <= '0;
      resp_word           <= '0;
      idle_timer          <= '0;
      clk_div_write_pulse <= 1'b0;
      clk_div_option      <= 1'b0;
      clk_div_out_enable  <= 1'b0;
      clk_div_divider     <= '0;
      clk_div_pulse       <= '0;
      reset_core          <= 1'b1;
      mem_read            <= 1'b0;
      mem_write           <= 1'b0;
      mem_address         <= '0;
      mem_write_data      <= '0;
    end else begin
      clk_div_write_pulse <= 1'b0;
      idle_timer          <= (timer_armed && rx_fifo_empty) ? idle_timer + 1'b1 : '0;
      case (state)
        FETCH, DATA_FETCH: if (timed_out) cnt <= '0;
        CAPTURE: begin
          cmd_word[{cnt, 3'b000} +: 8] <= rx_fifo_read_data;
          cnt                          <= cnt + 1'b1;
        end
        DATA_CAPTURE: begin
          mem_write_data[{cnt, 3'b000} +: 8] <= rx_fifo_read_data;
          cnt                                <= cnt + 1'b1;
          if (cnt == 2'd3) mem_write <= 1'b1;
        end
        DECODE: begin
          resp_word <= RESP_ACK;
          case (op)
            OP_PULSE: begin
              clk_div_option      <= 1'b0;
              clk_div_out_enable  <= 1'b1;
              clk_div_pulse       <= {8'h00, cmd_arg};
              clk_div_write_pulse <= 1'b1;
            end
            OP_AUTO: begin
              clk_div_option      <= 1'b1;
              clk_div_out_enable  <= 1'b1;
              clk_div_divider     <= {8'h00, cmd_arg};
              clk_div_write_pulse <= 1'b1;
            end
            OP_STOP: begin
              clk_div_out_enable  <= 1'b0;
              clk_div_write_pulse <= 1'b1;
            end
            OP_RESET: reset_core  <= cmd_arg[0];
            OP_WRITE: mem_address <= {6'b0, cmd_arg, 2'b00};
            OP_LOAD: begin
              mem_address <= {6'b0, cmd_arg, 2'b00};
              mem_read    <= 1'b1;
            end
            OP_PING: resp_word <= RESP_PONG;
            default: resp_word <= RESP_ERR;
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) resp_word <= mem_read_data;
          end
        end
        RESP: if (!tx_fifo_full) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_command_decoder.sv
// Randomized bench for uart_command_decoder: FIFO/memory environment plus a
// command-level reference model of the divider, reset and memory effects.
module tb_uart_command_decoder;

  localparam int TIMEOUT = 16;
  localparam logic [31:0] ACK  = 32'h0000_4B4F;
  localparam logic [31:0] ERR  = 32'hFFFF_FFFF;
  localparam logic [31:0] PONG = 32'h504F_4E47;

  logic        clk, resetn;
  logic        rx_fifo_empty, rx_fifo_read;
  logic [7:0]  rx_fifo_read_data;
  logic        tx_fifo_full, tx_fifo_write;
  logic [7:0]  tx_fifo_write_data;
  logic        clk_div_write_pulse, clk_div_option, clk_div_out_enable;
  logic [31:0] clk_div_divider, clk_div_pulse;
  logic        reset_core, mem_read, mem_write, mem_ack, busy;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  uart_command_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_read(rx_fifo_read), .rx_fifo_read_data(rx_fifo_read_data),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_write(tx_fifo_write), .tx_fifo_write_data(tx_fifo_write_data),
    .clk_div_write_pulse(clk_div_write_pulse), .clk_div_option(clk_div_option),
    .clk_div_out_enable(clk_div_out_enable), .clk_div_divider(clk_div_divider),
    .clk_div_pulse(clk_div_pulse), .reset_core(reset_core),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ack(mem_ack),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Environment state
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_got[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] sim_mem[logic [31:0]];
  int          pulse_count = 0;
  int          ack_delay_cfg = -1;
  int          stall_cnt = 0;
  bit          rand_full = 0;

  // Reference model state
  logic        m_option, m_oe, m_rst;
  logic [31:0] m_div, m_pulse;
  int          m_pulses = 0;
  logic [31:0] ref_mem[logic [31:0]];

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] sim_read(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : mem_default(a);
  endfunction

  // RX/TX FIFO and memory responder: observe at negedge, drive at posedge+1.
  initial begin
    bit pop_pending, pulse_prev, acked_prev, req_active, req;
    int delay;
    pulse_prev = 0; acked_prev = 0; req_active = 0; delay = 0;
    rx_fifo_empty = 1'b1; rx_fifo_read_data = '0; tx_fifo_full = 1'b0;
    mem_ack = 1'b0; mem_read_data = '0;
    forever begin
      @(negedge clk);
      pop_pending = rx_fifo_read;
      if (tx_fifo_write) tx_got.push_back(tx_fifo_write_data);
      if (clk_div_write_pulse) begin
        pulse_count++;
        check("write_pulse_width", {31'b0, pulse_prev}, 32'd0);
      end
      pulse_prev = clk_div_write_pulse;
      req = mem_read | mem_write;
      if (mem_ack) begin
        if (mem_write) begin
          wr_addr_log.push_back(mem_address);
          wr_data_log.push_back(mem_write_data);
          sim_mem[mem_address] = mem_write_data;
        end
        acked_prev = 1;
      end else if (acked_prev) begin
        check("req_drop_after_ack", {31'b0, req}, 32'd0);
        acked_prev = 0;
      end else if (req_active && resetn) begin
        check("req_held_until_ack", {31'b0, req}, 32'd1);
      end

      @(posedge clk);
      #1;
      if (pop_pending) begin
        if (rx_q.size() == 0) check("rx_underflow", 32'd1, 32'd0);
        else rx_fifo_read_data = rx_q.pop_front();
      end
      rx_fifo_empty = (rx_q.size() == 0);
      tx_fifo_full  = (stall_cnt > 0) || (rand_full && $urandom_range(0, 3) == 0);
      if (stall_cnt > 0) stall_cnt--;
      if (!resetn) begin
        req_active = 0;
        mem_ack    = 1'b0;
        acked_prev = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_read || mem_write) begin
        if (!req_active) begin
          req_active = 1;
          delay = (ack_delay_cfg < 0) ? int'($urandom_range(0, 4)) : ack_delay_cfg;
        end
        if (delay == 0) begin
          mem_ack       = 1'b1;
          mem_read_data = sim_read(mem_address);
          req_active    = 0;
        end else begin
          delay--;
        end
      end
    end
  end

  task automatic model_reset();
    m_option = 0; m_oe = 0; m_rst = 1; m_div = '0; m_pulse = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    rx_q.delete();
    stall_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_reset_core", {31'b0, reset_core}, 32'd1);
    check("rst_strobes", {24'b0, rx_fifo_read, tx_fifo_write, clk_div_write_pulse, clk_div_option,
                          clk_div_out_enable, mem_read, mem_write, busy}, 32'd0);
    check("rst_divider", clk_div_divider, 32'd0);
    check("rst_pulse", clk_div_pulse, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_tx_data", {24'b0, tx_fifo_write_data}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [23:0] arg, input logic [31:0] data);
    logic [31:0] word, addr, exp_resp, got_resp;
    int base, wbase;
    word = {arg, op};
    addr = {6'b0, arg, 2'b00};
    exp_resp = ACK;
    case (op)
      8'h43: begin m_option = 0; m_oe = 1; m_pulse = {8'h00, arg}; m_pulses++; end
      8'h41: begin m_option = 1; m_oe = 1; m_div = {8'h00, arg}; m_pulses++; end
      8'h53: begin m_oe = 0; m_pulses++; end
      8'h52: m_rst = arg[0];
      8'h57: ref_mem[addr] = data;
      8'h4C: exp_resp = ref_mem.exists(addr) ? ref_mem[addr] : mem_default(addr);
      8'h70: exp_resp = PONG;
      default: exp_resp = ERR;
    endcase
    base  = tx_got.size();
    wbase = wr_addr_log.size();
    for (int i = 0; i < 4; i++) rx_q.push_back(word[8*i +: 8]);
    if (op == 8'h57) for (int i = 0; i < 4; i++) rx_q.push_back(data[8*i +: 8]);
    for (int c = 0; c < 3000 && (tx_got.size() < base + 4 || busy); c++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    got_resp = 'x;
    if (tx_got.size() >= base + 4)
      got_resp = {tx_got[base+3], tx_got[base+2], tx_got[base+1], tx_got[base]};
    check($sformatf("resp_op%02h", op), got_resp, exp_resp);
    check("resp_len", tx_got.size() - base, 32'd4);
    check("option", {31'b0, clk_div_option}, {31'b0, m_option});
    check("out_enable", {31'b0, clk_div_out_enable}, {31'b0, m_oe});
    check("divider", clk_div_divider, m_div);
    check("pulse", clk_div_pulse, m_pulse);
    check("reset_core", {31'b0, reset_core}, {31'b0, m_rst});
    check("pulse_count", pulse_count, m_pulses);
    check("mem_write_count", wr_addr_log.size() - wbase, (op == 8'h57) ? 32'd1 : 32'd0);
    if (op == 8'h57 && wr_addr_log.size() > wbase) begin
      check("mem_write_addr", wr_addr_log[wbase], addr);
      check("mem_write_data", wr_data_log[wbase], data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops[8];
    int b0;
    ops = '{8'h43, 8'h41, 8'h53, 8'h52, 8'h57, 8'h4C, 8'h70, 8'h00};
    do_reset();

    run_cmd(8'h70, 24'h0, 32'h0);                          // ping after reset
    run_cmd(8'h41, 24'h000010, 32'h0);                     // auto mode divider=0x10

    ack_delay_cfg = 3;
    run_cmd(8'h57, 24'h000004, 32'hDEAD_BEEF);             // write to 0x10
    check("write_address", mem_address, 32'h0000_0010);

    ref_mem[32'h10] = 32'h1234_5678;
    sim_mem[32'h10] = 32'h1234_5678;
    b0 = tx_got.size();
    fork
      run_cmd(8'h4C, 24'h000004, 32'h0);
      begin
        for (int c = 0; c < 2000 && tx_got.size() < b0 + 2; c++) @(negedge clk);
        stall_cnt = 5;
      end
    join
    ack_delay_cfg = -1;

    // Partial word abandoned by the idle timeout, then a fresh ping.
    rx_q.push_back(8'h41);
    rx_q.push_back(8'h10);
    repeat (30) @(negedge clk);
    #1;
    check("timeout_idle", {31'b0, busy}, 32'd0);
    check("timeout_no_strobe", pulse_count, m_pulses);
    run_cmd(8'h70, 24'h0, 32'h0);

    run_cmd(8'h00, 24'h0, 32'h0);                          // unknown op
    run_cmd(8'h52, 24'h000000, 32'h0);                     // release core reset
    run_cmd(8'h43, 24'hABCDEF, 32'h0);                     // pulse mode
    run_cmd(8'h53, 24'h0, 32'h0);                          // stop

    rand_full = 1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] op;
      logic [23:0] arg;
      op  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : ops[$urandom_range(0, 7)];
      arg = (op == 8'h57 || op == 8'h4C) ? 24'($urandom_range(0, 7)) : 24'($urandom);
      run_cmd(op, arg, $urandom);
    end
    rand_full = 0;

    // Reset while a read waits for an ack that never comes.
    ack_delay_cfg = 100000;
    b0 = tx_got.size();
    for (int i = 0; i < 4; i++) rx_q.push_back(8'(i == 0 ? 8'h4C : (i == 1 ? 8'h01 : 8'h00)));
    for (int c = 0; c < 200 && !mem_read; c++) @(negedge clk);
    #1;
    check("stuck_read_req", {31'b0, mem_read}, 32'd1);
    check("stuck_busy", {31'b0, busy}, 32'd1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("async_mem_read_drop", {31'b0, mem_read}, 32'd0);
    check("async_busy_drop", {31'b0, busy}, 32'd0);
    check("async_reset_core", {31'b0, reset_core}, 32'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    ack_delay_cfg = -1;
    repeat (20) @(negedge clk);
    #1;
    check("no_resp_after_reset", tx_got.size() - b0, 32'd0);
    check("idle_after_reset", {31'b0, busy}, 32'd0);
    run_cmd(8'h70, 24'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_command_decoder.md
# uart_command_decoder

Command front end of the processor-ci controller. Sits downstream of the UART RX FIFO and upstream of the TX FIFO. Pops received bytes and assembles them into 32-bit command words. Executes each command against the core clock divider, the core reset or the core memory port, then pushes a 4-byte response word into the TX FIFO.

## Interface
- `TIMEOUT_CYCLES`, default 2500000 — maximum idle cycles allowed between bytes of one word before the partial word is discarded (100 ms at 25 MHz).
- `clk` in 1 — system clock; all logic on its rising edge.
- `resetn` in 1 — reset, asynchronous and active-low.
- `rx_fifo_empty` in 1 — RX FIFO has no data.
- `rx_fifo_read` out 1 — one-cycle pop strobe.
- `rx_fifo_read_data` in 8 — popped byte; valid the cycle after `rx_fifo_read`.
- `tx_fifo_full` in 1 — TX FIFO cannot accept a byte.
- `tx_fifo_write` out 1 — one-cycle push strobe.
- `tx_fifo_write_data` out 8 — byte to push.
- `clk_div_write_pulse` out 1 — one-cycle strobe; divider latches option/out_enable/divider/pulse.
- `clk_div_option` out 1 — 0 = pulse mode, 1 = auto mode.
- `clk_div_out_enable` out 1 — core clock output enable.
- `clk_div_divider` out 32 — auto-mode divide value.
- `clk_div_pulse` out 32 — pulse-mode cycle count.
- `reset_core` out 1 — core reset level, active-high.
- `mem_read` / `mem_write` out 1 — memory request, held until `mem_ack`.
- `mem_address` out 32 — byte address, word aligned.
- `mem_write_data` out 32 — write data.
- `mem_read_data` in 32 — read data; sampled in the `mem_ack` cycle.
- `mem_ack` in 1 — request complete.
- `busy` out 1 — high in every state except IDLE.

## Operation
- Words are received LSB byte first. `op` = word[7:0]; `arg` = word[31:8], zero-extended to 32 bits.
- Responses are 4-byte words, sent LSB first.
  - ACK = 0x00004B4F.
  - ERR = 0xFFFFFFFF.
  - PONG = 0x504F4E47.
- Commands:
  - 0x43 'C': option=0, out_enable=1, pulse=arg, strobe write_pulse; respond ACK.
  - 0x41 'A': option=1, out_enable=1, divider=arg, strobe write_pulse; respond ACK.
  - 0x53 'S': out_enable=0, strobe write_pulse; respond ACK.
  - 0x52 'R': reset_core=arg[0]; respond ACK.
  - 0x57 'W': collect 4 more bytes as data (LSB first). Then mem_write with address {6'b0, arg, 2'b00}. Respond ACK after mem_ack.
  - 0x4C 'L': mem_read at {6'b0, arg, 2'b00}. Respond with mem_read_data.
  - 0x70 'p': respond PONG.
  - Any other op: respond ERR; no other side effect.
- FSM states: IDLE, FETCH, CAPTURE, DECODE, DATA_FETCH, DATA_CAPTURE, MEM, RESP.
  - IDLE/FETCH: if !rx_fifo_empty, pulse rx_fifo_read, then go to CAPTURE.
  - CAPTURE: store byte at index cnt (2-bit counter), cnt++. If cnt wraps 3→0, go to DECODE; else go to FETCH.
  - DECODE: apply the command and load the response word. Then go to RESP, or to DATA_FETCH ('W'), or to MEM ('L').
  - DATA_FETCH/DATA_CAPTURE: same as FETCH/CAPTURE, filling the data register. After 4 bytes, go to MEM.
  - MEM: hold request until mem_ack. Then go to RESP.
  - RESP: push one byte per cycle while !tx_fifo_full. After byte 3, go to IDLE.
- Timeout: a counter runs in FETCH/DATA_FETCH while at least one byte of the current word has been captured. It clears on every capture. On reaching TIMEOUT_CYCLES, discard the partial word, cnt=0, go to IDLE, send no response. The timeout never applies in IDLE, MEM or RESP.
- Reset values:
  - All strobes, mem_read, mem_write, option, out_enable and busy are 0.
  - divider, pulse, mem_address and mem_write_data are 0.
  - reset_core = 1, so the core is held in reset until an 'R' with arg[0]=0.
  - cnt = 0; state = IDLE.

## Timing
- At most one RX read is outstanding, so intake is 1 byte per 2 cycles maximum.
- Decode latency: the cycle after the 4th capture, register outputs and strobes update (DECODE edge). The first response byte is pushed the following cycle if TX is not full.
- write_pulse is high for exactly one cycle. option/out_enable/divider/pulse are already valid in that cycle and hold afterwards.
- mem_read/mem_write assert the cycle after DECODE (or after the last data capture). They deassert the cycle after mem_ack. mem_ack outside MEM is ignored.
- tx_fifo_full stalls RESP indefinitely. The byte is held and no byte is dropped or duplicated.
- A missing mem_ack hangs in MEM with busy high. Recovery is by resetn only.
- resetn asserted mid-operation: immediate return to reset values. Any partial word or pending response is lost.

## Test plan
- Reset: check reset_core=1 and all other outputs 0. Push 0x70,0,0,0 → TX receives 0x47,0x4E,0x4F,0x50; write_pulse never fires.
- 'A' command: bytes 0x41,0x10,0x00,0x00 → divider=0x10, option=1, out_enable=1, write_pulse high for 1 cycle. TX receives 0x4F,0x4B,0x00,0x00.
- Write: 0x57,0x04,0x00,0x00 then 0xEF,0xBE,0xAD,0xDE; mem_ack after 3 cycles → mem_address=0x10, mem_write_data=0xDEADBEEF, request held exactly until ack, then ACK is returned.
- Read: 0x4C,0x04,0,0 with mem_read_data=0x12345678 on ack → TX receives 0x78,0x56,0x34,0x12. Hold tx_fifo_full for 5 cycles mid-response → no loss or duplication.
- Timeout (TIMEOUT_CYCLES=16): send 0x41,0x10, wait 20 cycles, then send 0x70,0,0,0 → no divider strobe; response is PONG only.
- Op 0x00 → ERR bytes 0xFF×4. Assert resetn during a read's MEM state → mem_read drops asynchronously, no response, FSM back in IDLE.
